// File: rtl/nx_ia_sw_port_arb_if.sv
// Bus bundle shared by the indirect access controller, the hardware port and one RAM/CAM port.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface nx_ia_sw_port_arb_if #(
   parameter int unsigned N_ENTRIES   = 1,
   parameter int unsigned N_DATA_BITS = 32
);
   localparam int unsigned AW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
   localparam int unsigned IW = ((N_ENTRIES / 2) > 1) ? $clog2(N_ENTRIES / 2) : 1;

   logic                   sw_cs;
   logic                   sw_we;
   logic                   sw_ce;
   logic [AW-1:0]          sw_add;
   logic [N_DATA_BITS-1:0] sw_wdat;
   logic                   yield;
   logic                   grant;
   logic                   rsp;
   logic [N_DATA_BITS-1:0] sw_rdat;
   logic                   sw_match;
   logic [IW-1:0]          sw_aindex;

   logic                   hw_cs;
   logic                   hw_we;
   logic [AW-1:0]          hw_add;
   logic [N_DATA_BITS-1:0] hw_wdat;
   logic                   hw_stall;
   logic                   hw_rvld;
   logic [N_DATA_BITS-1:0] hw_rdat;

   logic                   mem_cs;
   logic                   mem_we;
   logic                   mem_ce;
   logic [AW-1:0]          mem_add;
   logic [N_DATA_BITS-1:0] mem_wdat;
   logic [N_DATA_BITS-1:0] mem_rdat;
   logic                   mem_match;
   logic [IW-1:0]          mem_aindex;

   logic                   stall_clr;
   logic [15:0]            stall_cnt;

   modport slave (
      input  sw_cs, sw_we, sw_ce, sw_add, sw_wdat, yield,
      input  hw_cs, hw_we, hw_add, hw_wdat,
      input  mem_rdat, mem_match, mem_aindex, stall_clr,
      output grant, rsp, sw_rdat, sw_match, sw_aindex,
      output hw_stall, hw_rvld, hw_rdat,
      output mem_cs, mem_we, mem_ce, mem_add, mem_wdat, stall_cnt
   );

   modport master (
      output sw_cs, sw_we, sw_ce, sw_add, sw_wdat, yield,
      output hw_cs, hw_we, hw_add, hw_wdat,
      output mem_rdat, mem_match, mem_aindex, stall_clr,
      input  grant, rsp, sw_rdat, sw_match, sw_aindex,
      input  hw_stall, hw_rvld, hw_rdat,
      input  mem_cs, mem_we, mem_ce, mem_add, mem_wdat, stall_cnt
   );
endinterface

// File: rtl/nx_ia_sw_port_arb.sv
// Muxes the controller's software port and the hardware port onto one RAM/CAM command bus
// and routes read/compare results back to the issuing port through a tag pipeline.
module nx_ia_sw_port_arb #(
   parameter int unsigned N_ENTRIES   = 1,
   parameter int unsigned N_DATA_BITS = 32,
   parameter int unsigned RD_LATENCY  = 1
) (
   input logic                clk,
   input logic                rst,
   nx_ia_sw_port_arb_if.slave bus
);
   localparam int unsigned IW   = ((N_ENTRIES / 2) > 1) ? $clog2(N_ENTRIES / 2) : 1;
   localparam int unsigned Last = RD_LATENCY - 1;

   logic sel_sw;

   always_comb begin
      sel_sw       = bus.sw_cs && (!bus.hw_cs || bus.yield);
      bus.grant    = sel_sw;
      bus.hw_stall = bus.hw_cs && sel_sw;
      bus.mem_cs   = sel_sw || bus.hw_cs;
      bus.mem_we   = 1'b0;
      bus.mem_add  = '0;
      bus.mem_wdat = '0;
      if (sel_sw) begin
         bus.mem_we   = bus.sw_we;
         bus.mem_add  = bus.sw_add;
         bus.mem_wdat = bus.sw_wdat;
      end else if (bus.hw_cs) begin
         bus.mem_we   = bus.hw_we;
         bus.mem_add  = bus.hw_add;
         bus.mem_wdat = bus.hw_wdat;
      end
      // Write wins over compare; the hardware port never compares.
      bus.mem_ce = sel_sw && bus.sw_ce && !bus.sw_we;
   end

   logic [RD_LATENCY-1:0] vld_q, vld_d, own_q, own_d, cmp_q, cmp_d;

   always_comb begin
      vld_d    = vld_q;
      own_d    = own_q;
      cmp_d    = cmp_q;
      vld_d[0] = bus.mem_cs && !bus.mem_we;
      own_d[0] = sel_sw;
      cmp_d[0] = bus.mem_ce;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         own_d[i] = own_q[i-1];
         cmp_d[i] = cmp_q[i-1];
      end
   end

   logic                   sw_hit, hw_hit;
   logic [N_DATA_BITS-1:0] sw_rdat_q, sw_rdat_d, hw_rdat_q, hw_rdat_d;
   logic                   sw_match_q, sw_match_d;
   logic [IW-1:0]          sw_aindex_q, sw_aindex_d;
   logic [15:0]            stall_cnt_q, stall_cnt_d;

   // Results are forwarded in the cycle memory presents them and held in the _q copies.
   always_comb begin
      sw_hit      = vld_q[Last] && own_q[Last];
      hw_hit      = vld_q[Last] && !own_q[Last];
      sw_rdat_d   = sw_rdat_q;
      sw_match_d  = sw_match_q;
      sw_aindex_d = sw_aindex_q;
      hw_rdat_d   = hw_rdat_q;
      if (sw_hit) begin
         sw_rdat_d = bus.mem_rdat;
         if (cmp_q[Last]) begin
            sw_match_d  = bus.mem_match;
            sw_aindex_d = bus.mem_aindex;
         end
      end
      if (hw_hit) begin
         hw_rdat_d = bus.mem_rdat;
      end
      stall_cnt_d = stall_cnt_q;
      if (bus.stall_clr) begin
         stall_cnt_d = '0;
      end else if (bus.hw_stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q       <= '0;
         own_q       <= '0;
         cmp_q       <= '0;
         sw_rdat_q   <= '0;
         sw_match_q  <= 1'b0;
         sw_aindex_q <= '0;
         hw_rdat_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         vld_q       <= vld_d;
         own_q       <= own_d;
         cmp_q       <= cmp_d;
         sw_rdat_q   <= sw_rdat_d;
         sw_match_q  <= sw_match_d;
         sw_aindex_q <= sw_aindex_d;
         hw_rdat_q   <= hw_rdat_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      bus.rsp       = sw_hit;
      bus.hw_rvld   = hw_hit;
      bus.sw_rdat   = sw_rdat_d;
      bus.sw_match  = sw_match_d;
      bus.sw_aindex = sw_aindex_d;
      bus.hw_rdat   = hw_rdat_d;
      bus.stall_cnt = stall_cnt_q;
   end
endmodule

// File: tb/tb_nx_ia_sw_port_arb.sv
// Bench for nx_ia_sw_port_arb: arbitration table, directed corner sequences and random traffic
// checked against a transaction-level model with a response queue.
module tb_nx_ia_sw_port_arb;
   localparam int unsigned NE  = 16;
   localparam int unsigned DW  = 32;
   localparam int unsigned LAT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   nx_ia_sw_port_arb_if #(.N_ENTRIES(NE), .N_DATA_BITS(DW)) bus ();

   nx_ia_sw_port_arb #(
      .N_ENTRIES  (NE),
      .N_DATA_BITS(DW),
      .RD_LATENCY (LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   function automatic logic [31:0] data_of(input logic [3:0] a);
      if (a == 4'd5) return 32'hDEADBEEF;
      return 32'h5A00_000C | (32'(a) << 16) | (32'(a) << 4);
   endfunction

   // Memory stub: answers a read LAT cycles after it was issued, garbage otherwise.
   typedef struct packed {
      logic        rd;
      logic        cmp;
      logic [3:0]  add;
      logic [31:0] key;
      logic [31:0] junk;
      logic [2:0]  jidx;
   } cmd_t;
   cmd_t hist_q [LAT];

   always @(posedge clk) begin
      hist_q[0] <= '{rd: bus.mem_cs && !bus.mem_we, cmp: bus.mem_ce, add: bus.mem_add,
                     key: bus.mem_wdat, junk: 32'($urandom), jidx: 3'($urandom)};
      for (int i = 1; i < int'(LAT); i++) hist_q[i] <= hist_q[i-1];
   end

   always_comb begin
      bus.mem_rdat   = hist_q[LAT-1].rd ? data_of(hist_q[LAT-1].add) : hist_q[LAT-1].junk;
      bus.mem_match  = hist_q[LAT-1].cmp ? hist_q[LAT-1].key[2] : 1'b0;
      bus.mem_aindex = hist_q[LAT-1].cmp ? hist_q[LAT-1].key[6:4] : hist_q[LAT-1].jidx;
   end

   // Reference model state
   typedef struct {
      int          due;
      bit          sw;
      bit          cmp;
      logic [31:0] data;
      bit          match;
      logic [2:0]  idx;
   } exp_t;
   exp_t        eq[$];
   logic [31:0] m_sw_rdat, m_hw_rdat;
   logic        m_match;
   logic [2:0]  m_idx;
   int          m_stall;
   int          cyc;
   int          total, bad;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic idle();
      bus.sw_cs = 1'b0; bus.sw_we = 1'b0; bus.sw_ce = 1'b0; bus.sw_add = '0; bus.sw_wdat = '0;
      bus.yield = 1'b0; bus.hw_cs = 1'b0; bus.hw_we = 1'b0; bus.hw_add = '0; bus.hw_wdat = '0;
      bus.stall_clr = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      eq.delete();
      m_sw_rdat = '0; m_hw_rdat = '0; m_match = 1'b0; m_idx = '0; m_stall = 0;
   endtask

   // Called at posedge+1 with inputs applied; checks at negedge, advances the model at posedge.
   task automatic step();
      bit          sel, own_hw, we, rd, pend, p_sw;
      logic [3:0]  add;
      logic [31:0] wd;
      exp_t        e;
      @(negedge clk);
      sel    = bus.sw_cs && (!bus.hw_cs || bus.yield);
      own_hw = !sel && bus.hw_cs;
      we     = sel ? bus.sw_we : (own_hw ? bus.hw_we : 1'b0);
      add    = sel ? bus.sw_add : (own_hw ? bus.hw_add : 4'd0);
      wd     = sel ? bus.sw_wdat : (own_hw ? bus.hw_wdat : 32'd0);
      rd     = (sel || own_hw) && !we;
      chk("grant", 64'(bus.grant), 64'(sel));
      chk("hw_stall", 64'(bus.hw_stall), 64'(sel && bus.hw_cs));
      chk("mem_cs", 64'(bus.mem_cs), 64'(sel || own_hw));
      chk("mem_we", 64'(bus.mem_we), 64'(we));
      chk("mem_ce", 64'(bus.mem_ce), 64'(sel && bus.sw_ce && !bus.sw_we));
      chk("mem_add", 64'(bus.mem_add), 64'(add));
      chk("mem_wdat", 64'(bus.mem_wdat), 64'(wd));
      pend = (eq.size() > 0) && (eq[0].due == cyc);
      p_sw = 1'b0;
      if (pend) begin
         e    = eq.pop_front();
         p_sw = e.sw;
         if (e.sw) begin
            m_sw_rdat = e.data;
            if (e.cmp) begin
               m_match = e.match;
               m_idx   = e.idx;
            end
         end else begin
            m_hw_rdat = e.data;
         end
      end
      chk("rsp", 64'(bus.rsp), 64'(pend && p_sw));
      chk("hw_rvld", 64'(bus.hw_rvld), 64'(pend && !p_sw));
      chk("sw_rdat", 64'(bus.sw_rdat), 64'(m_sw_rdat));
      chk("sw_match", 64'(bus.sw_match), 64'(m_match));
      chk("sw_aindex", 64'(bus.sw_aindex), 64'(m_idx));
      chk("hw_rdat", 64'(bus.hw_rdat), 64'(m_hw_rdat));
      chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_stall));
      @(posedge clk);
      if (!rst) begin
         if (rd) eq.push_back('{due: cyc + int'(LAT), sw: sel,
                                cmp: sel && bus.sw_ce && !bus.sw_we, data: data_of(add),
                                match: wd[2], idx: wd[6:4]});
         if (bus.stall_clr) m_stall = 0;
         else if (sel && bus.hw_cs && m_stall < 65535) m_stall++;
      end
      cyc++;
      #1;
   endtask

   typedef struct {
      logic [5:0] in;   // {sw_cs, sw_we, sw_ce, hw_cs, hw_we, yield}
      logic [4:0] ex;   // {grant, hw_stall, mem_cs, mem_we, mem_ce}
      logic [1:0] src;  // 0 none, 1 sw, 2 hw
   } vec_t;
   vec_t tbl[12];

   initial begin
      logic [3:0] exp_add;
      total = 0; bad = 0; cyc = 0;
      tbl[0]  = '{6'b000000, 5'b00000, 2'd0};
      tbl[1]  = '{6'b100000, 5'b10100, 2'd1};
      tbl[2]  = '{6'b110000, 5'b10110, 2'd1};
      tbl[3]  = '{6'b101000, 5'b10101, 2'd1};
      tbl[4]  = '{6'b111000, 5'b10110, 2'd1};
      tbl[5]  = '{6'b000100, 5'b00100, 2'd2};
      tbl[6]  = '{6'b000110, 5'b00110, 2'd2};
      tbl[7]  = '{6'b110100, 5'b00100, 2'd2};
      tbl[8]  = '{6'b100111, 5'b11100, 2'd1};
      tbl[9]  = '{6'b101101, 5'b11101, 2'd1};
      tbl[10] = '{6'b000001, 5'b00000, 2'd0};
      tbl[11] = '{6'b101110, 5'b00110, 2'd2};

      idle();
      do_reset();
      #3;
      chk("rst_rsp", 64'(bus.rsp), 64'd0);
      chk("rst_hw_rvld", 64'(bus.hw_rvld), 64'd0);
      chk("rst_sw_rdat", 64'(bus.sw_rdat), 64'd0);
      chk("rst_hw_rdat", 64'(bus.hw_rdat), 64'd0);
      chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
      chk("rst_mem_cs", 64'(bus.mem_cs), 64'd0);
      @(posedge clk); #1;
      step();
      rst = 1'b0;
      step();

      // Arbitration table
      for (int i = 0; i < 12; i++) begin
         {bus.sw_cs, bus.sw_we, bus.sw_ce, bus.hw_cs, bus.hw_we, bus.yield} = tbl[i].in;
         bus.sw_add = 4'hA; bus.hw_add = 4'h3;
         bus.sw_wdat = 32'h1111_2222; bus.hw_wdat = 32'h3333_4444;
         #2;
         exp_add = (tbl[i].src == 2'd1) ? 4'hA : ((tbl[i].src == 2'd2) ? 4'h3 : 4'h0);
         chk($sformatf("tbl%0d_ctl", i),
             64'({bus.grant, bus.hw_stall, bus.mem_cs, bus.mem_we, bus.mem_ce}), 64'(tbl[i].ex));
         chk($sformatf("tbl%0d_add", i), 64'(bus.mem_add), 64'(exp_add));
         step();
      end
      idle();
      repeat (LAT + 1) step();

      // SW read of addr 5, answered at T+LAT
      bus.sw_cs = 1'b1; bus.sw_add = 4'd5;
      #2; chk("rd5_grant", 64'(bus.grant), 64'd1);
      step(); idle(); step();
      #2;
      chk("rd5_rsp", 64'(bus.rsp), 64'd1);
      chk("rd5_data", 64'(bus.sw_rdat), 64'hDEADBEEF);
      step();

      // Hardware busy every cycle; software wins only while yield is set
      bus.stall_clr = 1'b1; step(); bus.stall_clr = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.hw_cs = 1'b1; bus.hw_we = 1'b0; bus.hw_add = 4'(k);
         bus.sw_cs = 1'b1; bus.sw_add = 4'd9; bus.yield = (k == 2);
         #2;
         chk($sformatf("yld%0d_grant", k), 64'(bus.grant), 64'(k == 2));
         chk($sformatf("yld%0d_stall", k), 64'(bus.hw_stall), 64'(k == 2));
         step();
      end
      idle();
      #2; chk("yld_stall_cnt", 64'(bus.stall_cnt), 64'd1);
      repeat (LAT + 1) step();

      // Compare hit, then a plain read must keep match/aindex
      bus.sw_cs = 1'b1; bus.sw_ce = 1'b1; bus.sw_wdat = 32'h1234; bus.sw_add = 4'd7;
      step(); idle(); step();
      #2;
      chk("cmp_rsp", 64'(bus.rsp), 64'd1);
      chk("cmp_match", 64'(bus.sw_match), 64'd1);
      chk("cmp_aindex", 64'(bus.sw_aindex), 64'd3);
      step();
      bus.sw_cs = 1'b1; bus.sw_add = 4'd2;
      step(); idle(); step();
      #2;
      chk("rd2_rsp", 64'(bus.rsp), 64'd1);
      chk("rd2_match_held", 64'(bus.sw_match), 64'd1);
      chk("rd2_data", 64'(bus.sw_rdat), 64'(data_of(4'd2)));
      step();

      // Alternating HW addr 1 / SW addr 2 reads
      for (int k = 0; k < 8; k++) begin
         bus.yield = 1'b1;
         bus.hw_cs = (k % 2 == 0); bus.hw_add = 4'd1;
         bus.sw_cs = (k % 2 == 1); bus.sw_add = 4'd2;
         step();
      end
      idle();
      repeat (LAT + 1) step();

      // Stall counter saturation and clear priority
      bus.stall_clr = 1'b1; step(); bus.stall_clr = 1'b0;
      bus.hw_cs = 1'b1; bus.hw_we = 1'b1; bus.sw_cs = 1'b1; bus.sw_we = 1'b1; bus.yield = 1'b1;
      repeat (70000) step();
      #2; chk("sat_cnt", 64'(bus.stall_cnt), 64'hFFFF);
      bus.stall_clr = 1'b1;
      step();
      idle();
      #2; chk("clr_cnt", 64'(bus.stall_cnt), 64'd0);
      step();

      // Reset one cycle after a SW read issues
      bus.sw_cs = 1'b1; bus.sw_add = 4'd4;
      step();
      idle();
      do_reset();
      #2;
      chk("mid_rst_rsp", 64'(bus.rsp), 64'd0);
      chk("mid_rst_sw_rdat", 64'(bus.sw_rdat), 64'd0);
      chk("mid_rst_match", 64'(bus.sw_match), 64'd0);
      chk("mid_rst_hw_rdat", 64'(bus.hw_rdat), 64'd0);
      step();
      rst = 1'b0;
      repeat (LAT + 2) step();

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         bus.sw_cs     = 1'($urandom_range(0, 1));
         bus.sw_we     = ($urandom_range(0, 3) == 0);
         bus.sw_ce     = 1'($urandom_range(0, 1));
         bus.sw_add    = 4'($urandom);
         bus.sw_wdat   = 32'($urandom);
         bus.hw_cs     = 1'($urandom_range(0, 1));
         bus.hw_we     = ($urandom_range(0, 3) == 0);
         bus.hw_add    = 4'($urandom);
         bus.hw_wdat   = 32'($urandom);
         bus.yield     = ($urandom_range(0, 2) == 0);
         bus.stall_clr = ($urandom_range(0, 15) == 0);
         step();
      end
      idle();
      repeat (LAT + 1) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
